// File: rtl/video_pkg.sv
// Shared constants, state encoding and word payload for the video line-buffer write path.
package video_pkg;

   localparam int unsigned PIX_WIDTH     = 16;
   localparam int unsigned WR_DATA_WIDTH = 2 * PIX_WIDTH;
   localparam int unsigned WR_ADDR_WIDTH = 8;
   localparam int unsigned RAM_DEPTH     = 2 ** WR_ADDR_WIDTH;
   localparam int unsigned NUM_BANKS     = 2;
   localparam int unsigned BANK_WORDS    = RAM_DEPTH / NUM_BANKS;

   typedef enum logic {
      S_WAIT_VS = 1'b0,
      S_RUN     = 1'b1
   } wr_state_e;

   // One RAM word: second pixel of the pair in the upper half.
   typedef struct packed {
      logic [PIX_WIDTH-1:0] hi;
      logic [PIX_WIDTH-1:0] lo;
   } pix_word_t;

   // True when addr is the last word of its bank (127 or 255).
   function automatic logic is_bank_last(input logic [WR_ADDR_WIDTH-1:0] addr);
      return &addr[WR_ADDR_WIDTH-2:0];
   endfunction

endpackage

// File: rtl/pix_pair_packer.sv
// Packs pixel pairs into one word; pads a lone trailing pixel when de drops mid-pair.
module pix_pair_packer
   import video_pkg::*;
(
   input  logic                 wr_clk,
   input  logic                 tb_wr_rst,
   input  logic                 clear,
   input  logic                 de_in,
   input  logic [PIX_WIDTH-1:0] pix_in,
   output pix_word_t            word_c,
   output logic                 word_valid_c
);

   logic                 phase_q;
   logic                 de_q;
   logic [PIX_WIDTH-1:0] lo_q;
   logic                 de_fall_c;

   assign de_fall_c = de_q & ~de_in;

   // Pair phase, de history and the held first pixel.
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         phase_q <= 1'b0;
         de_q    <= 1'b0;
         lo_q    <= '0;
      end else begin
         de_q <= de_in;
         if (clear) begin
            phase_q <= 1'b0;
         end else if (de_in) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
               lo_q <= pix_in;
            end
         end else if (de_fall_c) begin
            phase_q <= 1'b0;
         end
      end
   end

   // Complete word when the second pixel arrives or the line ends with one pending.
   always_comb begin
      word_c       = '0;
      word_valid_c = 1'b0;
      if (!clear && phase_q) begin
         if (de_in) begin
            word_c.hi    = pix_in;
            word_c.lo    = lo_q;
            word_valid_c = 1'b1;
         end else if (de_fall_c) begin
            word_c.hi    = '0;
            word_c.lo    = lo_q;
            word_valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/video_sdpram_wr_packer.sv
// Write stage for the 256x32 line-buffer SDPRAM: pixel packing, ping-pong bank tracking, burst requests.
module video_sdpram_wr_packer
   import video_pkg::*;
(
   input  logic                     wr_clk,
   input  logic                     tb_wr_rst,
   input  logic                     vs_in,
   input  logic                     de_in,
   input  logic [PIX_WIDTH-1:0]     pix_in,
   output logic [WR_DATA_WIDTH-1:0] wr_data,
   output logic [WR_ADDR_WIDTH-1:0] wr_addr,
   output logic                     wr_en,
   output logic                     burst_req,
   output logic                     burst_bank,
   input  logic                     burst_ack,
   output logic                     frame_start,
   output logic                     overflow
);

   wr_state_e                state_q;
   wr_state_e                state_n;
   logic                     vs_q;
   logic                     vs_rise_c;
   logic                     run_c;
   logic                     de_gated_c;

   pix_word_t                word_c;
   logic                     word_valid_c;

   logic [WR_ADDR_WIDTH-1:0] ptr_q;
   logic [WR_ADDR_WIDTH-1:0] ptr_n;
   logic [NUM_BANKS-1:0]     full_q;
   logic [NUM_BANKS-1:0]     full_n;
   logic                     rd_bank_q;
   logic                     rd_bank_n;
   logic                     ovf_n;
   logic                     wr_en_n;
   logic [WR_DATA_WIDTH-1:0] wr_data_n;
   logic [WR_ADDR_WIDTH-1:0] wr_addr_n;
   logic                     tgt_bank_c;

   assign vs_rise_c  = vs_in & ~vs_q;
   assign run_c      = (state_q == S_RUN) && !vs_rise_c;
   assign de_gated_c = de_in & run_c;
   assign tgt_bank_c = ptr_q[WR_ADDR_WIDTH-1];

   // Frame state register.
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         state_q <= S_WAIT_VS;
      end else begin
         state_q <= state_n;
      end
   end

   // Any vs rising edge (re)starts the frame.
   always_comb begin
      state_n = state_q;
      if (vs_rise_c) begin
         state_n = S_RUN;
      end
   end

   pix_pair_packer u_packer (
      .wr_clk       (wr_clk),
      .tb_wr_rst    (tb_wr_rst),
      .clear        (vs_rise_c),
      .de_in        (de_gated_c),
      .pix_in       (pix_in),
      .word_c       (word_c),
      .word_valid_c (word_valid_c)
   );

   // Next write, pointer, bank flags and drain bank; a write into a full bank is dropped.
   always_comb begin
      ptr_n     = ptr_q;
      full_n    = full_q;
      rd_bank_n = rd_bank_q;
      ovf_n     = overflow;
      wr_en_n   = 1'b0;
      wr_data_n = wr_data;
      wr_addr_n = wr_addr;

      if (burst_ack && burst_req) begin
         full_n[rd_bank_q] = 1'b0;
         rd_bank_n         = ~rd_bank_q;
      end

      if (vs_rise_c) begin
         ptr_n = '0;
         ovf_n = 1'b0;
      end else if (word_valid_c) begin
         if (full_q[tgt_bank_c]) begin
            ovf_n = 1'b1;
         end else begin
            wr_en_n   = 1'b1;
            wr_data_n = word_c;
            wr_addr_n = ptr_q;
            ptr_n     = ptr_q + WR_ADDR_WIDTH'(1);
            if (is_bank_last(ptr_q)) begin
               full_n[tgt_bank_c] = 1'b1;
            end
         end
      end
   end

   // Registered state and outputs.
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         vs_q        <= 1'b0;
         ptr_q       <= '0;
         full_q      <= '0;
         rd_bank_q   <= 1'b0;
         wr_en       <= 1'b0;
         wr_data     <= '0;
         wr_addr     <= '0;
         burst_req   <= 1'b0;
         burst_bank  <= 1'b0;
         frame_start <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         vs_q        <= vs_in;
         ptr_q       <= ptr_n;
         full_q      <= full_n;
         rd_bank_q   <= rd_bank_n;
         wr_en       <= wr_en_n;
         wr_data     <= wr_data_n;
         wr_addr     <= wr_addr_n;
         burst_req   <= full_n[rd_bank_n];
         burst_bank  <= rd_bank_n;
         frame_start <= vs_rise_c;
         overflow    <= ovf_n;
      end
   end

endmodule

// File: tb/tb_video_sdpram_wr_packer.sv
// Directed bench for video_sdpram_wr_packer with a write scoreboard.
module tb_video_sdpram_wr_packer;

   logic        wr_clk = 1'b0;
   logic        tb_wr_rst;
   logic        vs_in;
   logic        de_in;
   logic [15:0] pix_in;
   logic [31:0] wr_data;
   logic [7:0]  wr_addr;
   logic        wr_en;
   logic        burst_req;
   logic        burst_bank;
   logic        burst_ack;
   logic        frame_start;
   logic        overflow;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 wr_clk = ~wr_clk;

   video_sdpram_wr_packer dut (
      .wr_clk      (wr_clk),
      .tb_wr_rst   (tb_wr_rst),
      .vs_in       (vs_in),
      .de_in       (de_in),
      .pix_in      (pix_in),
      .wr_data     (wr_data),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .burst_req   (burst_req),
      .burst_bank  (burst_bank),
      .burst_ack   (burst_ack),
      .frame_start (frame_start),
      .overflow    (overflow)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: every RAM write must match the oldest expected write.
   always @(negedge wr_clk) begin
      if (!tb_wr_rst && wr_en) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write actual addr=%h data=%h required no write", wr_addr, wr_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.a));
            chk("wr_data", wr_data, e.d);
         end
      end
   end

   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic pix(input logic [15:0] p);
      de_in  = 1'b1;
      pix_in = p;
      step();
   endtask

   task automatic idle(input int n);
      de_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic vs_pulse();
      vs_in = 1'b1;
      step();
      chk("frame_start_hi", 32'(frame_start), 32'd1);
      step();
      chk("frame_start_lo", 32'(frame_start), 32'd0);
      vs_in = 1'b0;
      step();
   endtask

   // n consecutive pairs from pixel value base upward, written from address start.
   task automatic send_words(input int start, input int n, input int base);
      for (int i = 0; i < n; i++) begin
         logic [15:0] p0;
         logic [15:0] p1;
         exp_t        e;
         p0  = 16'(base + 2 * i);
         p1  = 16'(base + 2 * i + 1);
         e.a = 8'(start + i);
         e.d = {p1, p0};
         sb.push_back(e);
         pix(p0);
         pix(p1);
      end
   endtask

   initial begin
      tb_wr_rst = 1'b1;
      vs_in     = 1'b0;
      de_in     = 1'b0;
      pix_in    = '0;
      burst_ack = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      tb_wr_rst = 1'b0;
      step();
      chk("reset_flags", 32'({wr_en, burst_req, burst_bank, frame_start, overflow}), 32'd0);
      chk("reset_addr", 32'(wr_addr), 32'd0);
      chk("reset_data", wr_data, 32'd0);

      // Pixels before the first vs are ignored.
      pix(16'h1111);
      pix(16'h2222);
      idle(3);

      // Full bank 0: 256 pixels 0x0001..0x0100.
      vs_pulse();
      send_words(0, 127, 1);
      chk("req_before_127", 32'(burst_req), 32'd0);
      send_words(127, 1, 255);
      chk("req_after_127", 32'(burst_req), 32'd1);
      chk("bank_after_127", 32'(burst_bank), 32'd0);
      idle(3);

      // 3-pixel line: one pair, then a padded word.
      pix(16'hAAAA);
      pix(16'hBBBB);
      sb.push_back('{a: 8'd128, d: 32'hBBBB_AAAA});
      pix(16'hCCCC);
      sb.push_back('{a: 8'd129, d: 32'h0000_CCCC});
      idle(4);

      // Fill the rest of bank 1, then overflow into still-full bank 0.
      send_words(130, 126, 16'h1000);
      idle(2);
      pix(16'hDEAD);
      pix(16'hBEEF);
      chk("drop_wr_en", 32'(wr_en), 32'd0);
      chk("drop_overflow", 32'(overflow), 32'd1);
      idle(2);
      burst_ack = 1'b1;
      step();
      burst_ack = 1'b0;
      chk("ack0_req", 32'(burst_req), 32'd1);
      chk("ack0_bank", 32'(burst_bank), 32'd1);
      send_words(0, 1, 16'h5000);
      idle(2);
      chk("overflow_sticky", 32'(overflow), 32'd1);

      // Drain bank 1, restart the frame, and ack bank 0 while writing address 255.
      burst_ack = 1'b1;
      step();
      burst_ack = 1'b0;
      chk("ack1_req", 32'(burst_req), 32'd0);
      chk("ack1_bank", 32'(burst_bank), 32'd0);
      vs_pulse();
      chk("overflow_cleared", 32'(overflow), 32'd0);
      send_words(0, 128, 16'h2000);
      chk("bank0_full_req", 32'(burst_req), 32'd1);
      send_words(128, 127, 16'h3000);
      pix(16'h7001);
      sb.push_back('{a: 8'd255, d: 32'h7002_7001});
      burst_ack = 1'b1;
      pix(16'h7002);
      burst_ack = 1'b0;
      chk("ack_same_req", 32'(burst_req), 32'd1);
      chk("ack_same_bank", 32'(burst_bank), 32'd1);
      idle(2);
      burst_ack = 1'b1;
      step();
      burst_ack = 1'b0;
      chk("bank0_cleared_req", 32'(burst_req), 32'd0);
      chk("bank0_cleared_bank", 32'(burst_bank), 32'd0);
      burst_ack = 1'b1;
      step();
      burst_ack = 1'b0;
      chk("idle_ack_ignored", 32'({burst_req, burst_bank}), 32'd0);

      // Second vs mid-line with one pending pixel.
      send_words(0, 1, 16'h4000);
      idle(2);
      pix(16'h9999);
      de_in = 1'b0;
      vs_pulse();
      idle(3);
      send_words(0, 1, 16'h4100);
      idle(3);

      // Reset mid-pair.
      pix(16'h6001);
      de_in  = 1'b1;
      pix_in = 16'h6002;
      #2;
      tb_wr_rst = 1'b1;
      #1;
      chk("rst_mid_flags", 32'({wr_en, burst_req, burst_bank, frame_start, overflow}), 32'd0);
      chk("rst_mid_addr", 32'(wr_addr), 32'd0);
      chk("rst_mid_data", wr_data, 32'd0);
      de_in = 1'b0;
      step();
      step();
      tb_wr_rst = 1'b0;
      step();
      pix(16'h6003);
      pix(16'h6004);
      pix(16'h6005);
      idle(3);
      vs_pulse();
      send_words(0, 1, 16'h8000);
      idle(4);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
